// File: rtl/mac16_accumulator.sv
// Multiply-accumulate front end for multi16: sums len unsigned 16x16 products into an ACC_W accumulator.
// Latency: last pair accepted at edge E -> result valid after E+2; in_ready/out_valid handshake backpressure.
// Optional MAC16_SATURATE_EN: saturating accumulate with sticky out_sat (wraps when undefined).

module multi16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  // Behavioral form of the 16x16 tree multiplier; synthesis builds the reduction tree.
  assign p = {16'b0, a} * {16'b0, b};
endmodule

module mac16_accumulator #(
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        len_q, cnt;
  logic              start_acc, fire, last;
  logic              s0_vld, s1_vld;
  logic [15:0]       a_q, b_q;
  logic [31:0]       prod, prod_q;
  logic [ACC_W-1:0]  acc;

  assign fire    = in_valid && in_ready;
  assign last    = (cnt + 8'd1) == len_q;
  assign out_acc = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = (len == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = cnt < len_q;
        if (in_valid && last) state_nxt = DRAIN;
      end
      // Last pair has left stage 0 and is being summed on this edge.
      DRAIN: if (s1_vld && !s0_vld) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= 8'd0;
      cnt   <= 8'd0;
    end else if (start_acc) begin
      len_q <= len;
      cnt   <= 8'd0;
    end else if (fire) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld <= 1'b0;
      s1_vld <= 1'b0;
      a_q    <= 16'd0;
      b_q    <= 16'd0;
      prod_q <= 32'd0;
    end else begin
      s0_vld <= fire;
      s1_vld <= s0_vld;
      if (fire) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (s0_vld) prod_q <= prod;
    end
  end

  multi16 u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

`ifdef MAC16_SATURATE_EN
  logic [ACC_W:0] sum;
  logic           sat_q;

  assign sum     = {1'b0, acc} + (ACC_W+1)'(prod_q);
  assign out_sat = sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (start_acc) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (s1_vld) begin
      if (sum[ACC_W]) begin
        acc   <= '1;
        sat_q <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end
`else
  assign out_sat = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         acc <= '0;
    else if (start_acc) acc <= '0;
    else if (s1_vld)    acc <= acc + ACC_W'(prod_q);
  end
`endif

endmodule

// File: tb/tb_mac16_accumulator.sv
// Directed bench for mac16_accumulator: a 40-bit instance for the main flow, a 32-bit one for overflow.
module tb_mac16_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, out_ready;
  logic [7:0]  len;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, out_sat, busy;
  logic [39:0] out_acc;

  logic        start32, in_valid32, out_ready32;
  logic [7:0]  len32;
  logic [15:0] a32, b32;
  logic        in_ready32, out_valid32, sat32, busy32;
  logic [31:0] acc32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac16_accumulator #(.ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_sat(out_sat), .busy(busy)
  );

  mac16_accumulator #(.ACC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .len(len32),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_a(a32), .in_b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_acc(acc32),
    .out_sat(sat32), .busy(busy32)
  );

  // Present one pair and hold it until the block can take it; called at a negedge.
  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: in_ready low for %0d cycles, required high", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) begin
      n_cmp++; n_err++;
      $display("FAIL wait_out_timeout: out_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic start_job(input logic [7:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_acc !== 40'd0) begin n_err++; $display("FAIL reset_out_acc: got %h want 0", out_acc); end
    n_cmp++; if ({out_sat, busy} !== 2'b00) begin n_err++; $display("FAIL reset_sat_busy: got %b want 00", {out_sat, busy}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    start_job(8'd1);
    n_cmp++; if ({busy, in_ready} !== 2'b11) begin n_err++; $display("FAIL single_run: busy,in_ready got %b want 11", {busy, in_ready}); end
    in_valid = 1'b1; in_a = 16'd3; in_b = 16'd5;
    @(negedge clk);  // edge E accepted the pair
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_drop: got %b want 0", in_ready); end
    @(negedge clk);  // after E+1
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    @(negedge clk);  // after E+2
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_acc !== 40'd15) begin n_err++; $display("FAIL single_acc: got %0d want 15", out_acc); end
    n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL single_sat: got %b want 0", out_sat); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single_consume: valid,busy got %b want 00", {out_valid, busy}); end
  endtask

  task automatic test_back_to_back();
    int acc_edges = 0;
    start_job(8'd4);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      if (in_ready) acc_edges++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (acc_edges !== 4) begin n_err++; $display("FAIL b2b_accepts: got %0d want 4", acc_edges); end
    wait_out();
    n_cmp++; if (out_acc !== 40'h3_FFF8_0004) begin n_err++; $display("FAIL b2b_acc: got %h want 3fff80004", out_acc); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_gaps_backpressure();
    start_job(8'd3);
    push(16'd100, 16'd200);
    repeat (2) @(negedge clk);
    push(16'd7, 16'd9);
    @(negedge clk);
    push(16'h1234, 16'h0010);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_acc !== 40'd94623) begin
        n_err++; $display("FAIL gaps_hold%0d: valid=%b acc=%0d want 1/94623", i, out_valid, out_acc);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gaps_consume: got %b want 0", out_valid); end
    n_cmp++; if (out_acc !== 40'd94623) begin n_err++; $display("FAIL gaps_keep_acc: got %0d want 94623", out_acc); end
  endtask

  task automatic test_len_zero();
    start_job(8'd0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL len0_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_acc !== 40'd0) begin n_err++; $display("FAIL len0_acc: got %0d want 0", out_acc); end
    start_job(8'd5);
    n_cmp++; if ({out_valid, busy, in_ready} !== 3'b110) begin n_err++; $display("FAIL done_start_ignored: got %b want 110", {out_valid, busy, in_ready}); end
    out_ready = 1'b1; start = 1'b1; len = 8'd2;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL consume_start_ignored: got %b want 00", {out_valid, busy}); end
  endtask

  task automatic test_overflow32();
    int n = 0;
    start32 = 1'b1; len32 = 8'd2;
    @(negedge clk);
    start32 = 1'b0; in_valid32 = 1'b1; a32 = 16'hFFFF; b32 = 16'hFFFF;
    repeat (2) @(negedge clk);
    in_valid32 = 1'b0;
    while (!out_valid32 && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) begin n_cmp++; n_err++; $display("FAIL ovf_timeout: out_valid=0 after %0d cycles, required 1", n); end
`ifdef MAC16_SATURATE_EN
    n_cmp++; if (acc32 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ovf_acc: got %h want ffffffff", acc32); end
    n_cmp++; if (sat32 !== 1'b1) begin n_err++; $display("FAIL ovf_sat: got %b want 1", sat32); end
`else
    n_cmp++; if (acc32 !== 32'hFFFC_0002) begin n_err++; $display("FAIL ovf_acc: got %h want fffc0002", acc32); end
    n_cmp++; if (sat32 !== 1'b0) begin n_err++; $display("FAIL ovf_sat: got %b want 0", sat32); end
`endif
    out_ready32 = 1'b1;
    @(negedge clk);
    out_ready32 = 1'b0;
  endtask

  task automatic test_reset_midjob();
    start_job(8'd4);
    push(16'd10, 16'd10);
    push(16'd11, 16'd11);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid, busy, out_sat} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags: got %b want 0000", {in_ready, out_valid, busy, out_sat}); end
    n_cmp++; if (out_acc !== 40'd0) begin n_err++; $display("FAIL midrst_acc: got %0d want 0", out_acc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(8'd1);
    push(16'd2, 16'd2);
    wait_out();
    n_cmp++; if (out_acc !== 40'd4) begin n_err++; $display("FAIL midrst_next_job: got %0d want 4", out_acc); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; out_ready = 1'b0;
    start32 = 1'b0; len32 = 8'd0; in_valid32 = 1'b0; a32 = 16'd0; b32 = 16'd0; out_ready32 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps_backpressure();
    test_len_zero();
    test_overflow32();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mac16_accumulator.md
# mac16_accumulator

Sequential multiply-accumulate front end built around the existing 16x16 Wallace-tree multiplier (`multi16`). It accepts a programmed number of unsigned operand pairs over a valid/ready handshake, registers each pair into the multiplier, registers the 32-bit product, and sums the products into a wide accumulator. The final sum is presented on a valid/ready result port. The block sits directly upstream of `multi16`, which it feeds, and downstream of its product output, which it consumes.

## Interface
- `ACC_W`, 40: accumulator and result width in bits; legal range 32..48.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: single-cycle request to begin a job; sampled only in IDLE.
- `len` input 8: number of operand pairs in the job; sampled on the accepted `start`.
- `in_valid` input 1: operand pair `in_a`/`in_b` is valid.
- `in_ready` output 1: block accepts a pair this cycle.
- `in_a` input 16: unsigned multiplicand.
- `in_b` input 16: unsigned multiplier.
- `out_valid` output 1: `out_acc` holds the final job sum.
- `out_ready` input 1: consumer accepts the result.
- `out_acc` output ACC_W: accumulated sum.
- `out_sat` output 1: saturation occurred during the job. Constant 0 without the macro.
- `busy` output 1: high in every state except IDLE.

## Operation
- Reset values: `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_sat`=0, `busy`=0. All pipeline registers, counters and valid bits are cleared. FSM enters IDLE.
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE + `start`=1:
  - Capture `len`.
  - Clear accumulator and `out_sat`.
  - Go to RUN, or to DONE directly if `len`=0.
- IDLE + `start`=0: stay in IDLE.
- RUN:
  - `in_ready`=1 while accepted-count < `len`.
  - A pair is accepted on an edge where `in_valid`&&`in_ready`; accepted-count increments.
  - When the `len`-th pair is accepted, go to DRAIN. `in_ready` drops in the next cycle.
- DRAIN:
  - `in_ready`=0.
  - Wait until the last product has been added to the accumulator, then go to DONE.
- DONE:
  - `out_valid`=1. `out_acc` is stable.
  - On `out_ready`=1, return to IDLE. `out_valid` falls in the next cycle.
  - `out_acc` keeps the last sum until the next `start` is accepted.
- `start` outside IDLE is ignored and has no side effects.
- Pipeline:
  - Stage 0 is the operand register pair, loaded on acceptance, with a valid bit.
  - The `multi16` instance is driven from the stage 0 registers.
  - Stage 1 is the 32-bit product register with a valid bit.
  - Stage 2 is the accumulator, which adds the zero-extended product when the stage 1 valid bit is set.
- Arithmetic: the product is an exact unsigned 32-bit value. The accumulator wraps modulo 2^ACC_W when the macro is absent.
- `in_valid` deasserted mid-job: the pipeline bubbles and no pairs are lost or duplicated.

## Timing
- A pair accepted at edge E is registered at E, its product is registered at E+1, and it is accumulated at E+2.
- For the last pair accepted at edge E:
  - the FSM enters DONE at E+2;
  - `out_valid`=1 with the final sum in the cycle after E+2.
- Peak throughput is one pair per clock with back-to-back `in_valid`.
- `start` with `len`=0 at edge E: `out_valid`=1 with `out_acc`=0 in the cycle after E.
- `out_valid` and `out_ready` high at the same edge: the result is consumed. A `start` in that same cycle is ignored because the FSM is not yet in IDLE.
- `rst_n` low at any time, including mid-job or mid-result, forces the reset values immediately. A partial job is discarded.

## Configuration
- `MAC16_SATURATE_EN` defined: the accumulator adds with saturation.
  - A sum exceeding 2^ACC_W-1 clamps to 2^ACC_W-1.
  - `out_sat` becomes sticky 1 until the next accepted `start`.
- `MAC16_SATURATE_EN` undefined:
  - The accumulator wraps.
  - `out_sat` is tied to 0 and the saturation logic is absent.

## Test plan
- Reset, then `len`=1, pair (3, 5): `out_valid` in the cycle after E+2 with `out_acc`=15, `out_sat`=0.
- `len`=4, back-to-back pairs (0xFFFF,0xFFFF)x4: `out_acc`=4*0xFFFE0001=0x3FFF80004, and `in_ready` high for exactly 4 accepted edges.
- `len`=3 with `in_valid` gaps and `out_ready` held low for 5 cycles: correct sum, and `out_valid`/`out_acc` stable until `out_ready`.
- `len`=0: `out_acc`=0 one cycle after `start`; a `start` pulsed while in DONE is ignored.
- ACC_W=32, `len`=2, pairs (0xFFFF,0xFFFF)x2:
  - with the macro: `out_acc`=0xFFFFFFFF and `out_sat`=1;
  - without the macro: `out_acc`=0xFFFC0002 and `out_sat`=0.
- `rst_n` pulsed low after 2 of 4 pairs: outputs return to reset values; a following `len`=1, (2,2) job yields 4.
